// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, protection-region bit positions
// and the helpers the bridge and completer both use to map pprot onto addresses.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } apb_state_e;

    localparam int PROT_PRIV_BIT  = 4;
    localparam int PROT_NSEC_BIT  = 5;
    localparam int PROT_INSTR_BIT = 6;
    localparam int APB_ADDR_W     = 32;

    // Attributes a region demands, ordered like pprot: {instruction, non-secure, privileged}.
    function automatic logic [2:0] getPprot(input logic [APB_ADDR_W-1:0] addr);
        return {addr[PROT_INSTR_BIT], addr[PROT_NSEC_BIT], addr[PROT_PRIV_BIT]};
    endfunction

    function automatic logic [APB_ADDR_W-1:0] getAddrforPprot(
        input logic [2:0]            pprot,
        input logic [APB_ADDR_W-1:0] addr
    );
        logic [APB_ADDR_W-1:0] w_addr;
        w_addr                 = addr;
        w_addr[PROT_PRIV_BIT]  = pprot[0];
        w_addr[PROT_NSEC_BIT]  = pprot[1];
        w_addr[PROT_INSTR_BIT] = pprot[2];
        return w_addr;
    endfunction

endpackage

// File: rtl/apb_prot_unit.sv
// Combinational protection check: the transfer fails when the addressed region
// demands an attribute that the latched pprot does not grant.
module apb_prot_unit
    import apb_pkg::*;
(
    input  logic [APB_ADDR_W-1:0] i_paddr,
    input  logic [2:0]            i_pprot,
    output logic                  o_prot_err
);

    logic [2:0] w_req;

    assign w_req      = getPprot(i_paddr);
    assign o_prot_err = |(w_req & ~i_pprot);

endmodule

// File: rtl/apb_completer.sv
// APB completer: word register file with byte strobes, fixed wait states and
// pslverr on misaligned/out-of-range/protocol errors; protection check under APB_PROT_CHECK_EN.
module apb_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output apb_state_e              o_dbg_state
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam int         STRB_W    = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_e            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_strb;
    logic [2:0]            r_prot;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_setup;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_range_err;
    logic                  w_prot_err;
    logic                  w_err;
    logic                  w_violation;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_wmerge;

    assign w_setup     = psel && !penable;
    assign w_accept    = w_setup && (r_state == ST_IDLE || r_state == ST_RESP);
    assign w_misalign  = |paddr[1:0];
    assign w_range_err = |paddr[ADDR_WIDTH-1:IDX_W+2];
    assign w_err       = r_err | w_prot_err;
    assign w_idx       = r_addr[IDX_W+1:2];

    // The access phase must hold select, enable and every latched control stable.
    assign w_violation = !psel || !penable || (paddr != r_addr) || (pwrite != r_write)
                         || (pstrb != r_strb) || (pprot != r_prot);

`ifdef APB_PROT_CHECK_EN
    apb_prot_unit u_prot (
        .i_paddr    (APB_ADDR_W'(r_addr)),
        .i_pprot    (r_prot),
        .o_prot_err (w_prot_err)
    );
`else
    assign w_prot_err = 1'b0;
`endif

    always_comb begin
        w_wmerge = r_regs[w_idx];
        for (int i = 0; i < STRB_W; i++) begin
            if (r_strb[i]) begin
                w_wmerge[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prot    <= '0;
            r_err     <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_prot  <= pprot;
                r_err   <= w_misalign | w_range_err;
                r_cnt   <= WAIT_INIT;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_state <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (w_violation) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        r_prdata  <= '0;
                        r_state   <= ST_RESP;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_write && !w_err) begin
                            r_regs[w_idx] <= w_wmerge;
                        end
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= (!r_write && !w_err) ? r_regs[w_idx] : '0;
                        r_state   <= ST_RESP;
                    end
                end

                // Response is a single-cycle pulse; a new setup here skips IDLE.
                ST_RESP: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    r_state   <= w_setup ? ST_ACCESS : ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prdata      = r_prdata;
    assign pready      = r_pready;
    assign pslverr     = r_pslverr;
    assign o_dbg_state = r_state;

endmodule

// File: doc/apb_completer.md
# apb_completer

APB completer (peripheral) sitting directly downstream of the APB bridge: it consumes the bridge's setup/access transfers and produces `prdata`, `pready` and `pslverr`. It contains a word-addressed register file with byte-strobed writes and a programmable number of wait states. It flags misaligned, out-of-range, protection-violating and protocol-violating transfers with `pslverr`. It is the device under test for the bridge's read, invalid-read and protection sequences.

## Interface
- `ADDR_WIDTH`, 32: width of `paddr`.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`; must be 32.
- `NUM_REGS`, 32: register-file depth in words; power of two, at least 2.
- `WAIT_STATES`, 2: access-phase cycles with `pready` low before completion; 0..15.
- `pclk`  in  1  sole clock. All logic is on the rising edge.
- `preset`  in  1  reset; synchronous, active-high.
- `psel`  in  1  completer select.
- `penable`  in  1  access-phase indicator.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  write byte strobes.
- `pprot`  in  3  protection attributes: [0] privileged, [1] non-secure, [2] instruction.
- `prdata`  out  DATA_WIDTH  read data, valid only while `pready`=1.
- `pready`  out  1  transfer complete; a one-cycle pulse.
- `pslverr`  out  1  error; valid only while `pready`=1.

## Operation
- Word index: `paddr[$clog2(NUM_REGS)+1:2]`. The address is out of range if any `paddr` bit above that field is set.
- FSM states are IDLE, ACCESS and RESP.
- IDLE: on a sampled `psel`=1 and `penable`=0 (setup):
  - latch `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot`;
  - compute the error flag;
  - load the wait counter with WAIT_STATES;
  - go to ACCESS.
- ACCESS, with `psel`=1 and `penable`=1 sampled:
  - counter nonzero: decrement the counter and stay in ACCESS.
  - counter zero: perform the write if it is error-free; drive `pready`=1, `pslverr`=err, and `prdata` = register word (read, no error) or 0; go to RESP.
- ACCESS protocol violation: if `psel`=0 or `penable`=0 is sampled, or the latched address or controls change, the transfer completes on the next edge with `pready`=1 and `pslverr`=1. There is no register update and `prdata`=0. The FSM goes to RESP.
- RESP: `pready`, `pslverr` and `prdata` are held for exactly this one cycle, then cleared.
  - A setup sampled in RESP is accepted directly, giving back-to-back transfers with no IDLE cycle.
  - Anything else sampled in RESP returns the FSM to IDLE.
- Error flag = misaligned (`paddr[1:0]`≠0) OR out of range OR protection fail. Protection fail applies only with the macro defined; see Configuration.
- Writes: byte lane i is updated only when `pstrb[i]`=1. Reads ignore `pstrb`.
- `psel`=0 in IDLE: no state change.

## Timing
- Reset: `prdata`=0, `pready`=0, `pslverr`=0, FSM=IDLE, counter=0, all registers = 0.
- Reset mid-transfer: the transfer is abandoned with no pulse and no write. The cycle after the reset edge shows the reset values.
- Latency: edge S samples the setup. `pready` is high during the cycle after edge S+1+WAIT_STATES, provided the access phase holds.
- With WAIT_STATES=0, `pready` rises after the first access-phase edge.
- The register write takes effect on the same edge that raises `pready`. A read in the immediately following transfer returns the new value.
- Completion is never sooner than one access-phase edge; `pready` is never high in the setup phase.

## Configuration
- `APB_PROT_CHECK_EN` defined: protection is checked. The required attributes are `req = {paddr[6], paddr[5], paddr[4]}` for bits {instruction, non-secure, privileged}. The access fails when `(req & ~pprot) != 0`.
- `APB_PROT_CHECK_EN` undefined: `pprot` is ignored and the protection sub-module is not instantiated. Alignment, range and protocol errors remain.

## Structure
- `apb_pkg` holds:
  - the FSM state enum;
  - `PROT_PRIV_BIT`=4, `PROT_NSEC_BIT`=5, `PROT_INSTR_BIT`=6;
  - function `getPprot(addr)`, returning `req`;
  - function `getAddrforPprot(pprot, addr)`, which sets the region bits. The bridge uses the same functions.
- Sub-module `apb_prot_unit`: combinational check (latched `paddr`, `pprot` → `prot_err`), instantiated under the macro.

## Test plan
- Write/read: after reset, write 0xDEADBEEF to 0x4 with `pprot`=000 and `pstrb`=1111. Reading 0x4 returns 0xDEADBEEF with `pslverr`=0. `pready` arrives 3 edges after the setup edge (WAIT_STATES=2).
- Strobes: write 0x11223344 to 0x4 with `pstrb`=0101. Reading 0x4 returns 0xDE22BE44.
- Misaligned: read 0x3 gives `pready`=1, `pslverr`=1, `prdata`=0. Writing 0x3 leaves every register unchanged.
- Early `psel` drop: a read of 0x4 with `psel`=0 in the first access cycle gives a one-cycle pulse with `pready`=1 and `pslverr`=1. The next setup is accepted normally.
- Protection on 0x74, macro defined:
  - `pprot`=111 reads with no error.
  - 110, 101 and 011 each give `pslverr`=1.
  - With the macro undefined, all four reads give `pslverr`=0.
- Reset mid-ACCESS: assert `preset` during a wait state of a write to 0x8. No `pready` pulse follows, and reading 0x8 returns 0.
